// File: rtl/hbridge_pkg.sv
// Shared definitions for the H-bridge gate sequencer: FSM state encoding
// and the rule that picks the reserved all-off pattern source.
package hbridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BOOT  = 3'd1,
      ST_FORCE = 3'd2,
      ST_RUN   = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   // The highest mode index is the all-off source; anything at or above it
   // requests no gates.
   function automatic int all_off_mode(input int n_mode);
      return n_mode - 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hbridge_sequencer_dead_time.sv
// One gate's dead-time channel: a request must be seen high for DEADTIME+1
// consecutive samples before the gate turns on; a low request (or clr)
// turns the gate off at once and restarts the count.
module dead_time_channel #(
   parameter int DEADTIME = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic req,
   output logic q,
   output logic q_next
);

   localparam int CW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
   localparam logic [CW-1:0] DC = CW'(DEADTIME);

   logic [CW-1:0] cnt;

   // Value the gate would take at this edge, ignoring clr; the top uses it
   // to catch shoot-through before it ever reaches a pin.
   assign q_next = req && (cnt == DC);

   // Count consecutive high request samples, saturating at DEADTIME.
   always_ff @(posedge clk) begin
      if (!rst_n || clr || !req) begin
         cnt <= '0;
         q   <= 1'b0;
      end else begin
         q <= q_next;
         if (cnt != DC) cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hbridge_sequencer.sv
// H-bridge gate sequencer: bootstrap precharge, forced-sigma precharge,
// then mode-selected gate patterns, every gate filtered by its own
// dead-time channel, with fault latching and shoot-through detection.
module hbridge_sequencer
   import hbridge_pkg::*;
#(
   parameter int N_LEG    = 2,
   parameter int N_MODE   = 4,
   parameter int DEADTIME = 20,
   parameter int T_BOOT   = 1000,
   parameter int T_VG     = 1000
) (
   input  logic                                              i_clock,
   input  logic                                              i_RESET,
   input  logic                                              i_enable,
   input  logic [((N_MODE > 1) ? $clog2(N_MODE) : 1)-1:0]    i_mode,
   input  logic [2*N_LEG*N_MODE-1:0]                         i_MOSFET,
   input  logic                                              i_fault,
   output logic [2*N_LEG-1:0]                                o_Q,
   output logic [2:0]                                        o_state,
   output logic                                              o_fault,
   output logic                                              o_running
);

   localparam int NG      = 2 * N_LEG;
   localparam int ALL_OFF = all_off_mode(N_MODE);
   localparam int CNT_W   = $clog2(max_int(T_BOOT, T_VG)) + 1;
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'((T_BOOT > 1) ? T_BOOT - 1 : 0);
   localparam logic [CNT_W-1:0] VG_LAST   = CNT_W'((T_VG > 1) ? T_VG - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [NG-1:0]    req;
   logic [NG-1:0]    q_next;
   logic             overlap;
   logic             active;
   logic             kill;

   assign o_state = state;

   // Raw gate requests for the current state, before dead time.
   always_comb begin
      req = '0;
      case (state)
         ST_BOOT:  req[NG-1:N_LEG] = '1;
         ST_FORCE: begin
            req[0] = 1'b1;
            for (int k = 1; k < N_LEG; k++) req[N_LEG+k] = 1'b1;
         end
         ST_RUN:   if (int'(i_mode) < ALL_OFF) req = i_MOSFET[NG*int'(i_mode) +: NG];
         default:  req = '0;
      endcase
   end

   // Both sides of a leg about to be on is treated as a fault, and the
   // channels are cleared on the same edge so it never shows on o_Q.
   assign overlap = |(q_next[N_LEG-1:0] & q_next[NG-1:N_LEG]);
   assign active  = (state == ST_BOOT) || (state == ST_FORCE) || (state == ST_RUN);
   assign kill    = !active || i_fault || overlap || !i_enable;

   for (genvar g = 0; g < NG; g++) begin : g_dt
      dead_time_channel #(.DEADTIME(DEADTIME)) u_dt (
         .clk    (i_clock),
         .rst_n  (i_RESET),
         .clr    (kill),
         .req    (req[g]),
         .q      (o_Q[g]),
         .q_next (q_next[g])
      );
   end

   // Sequencer FSM with its state timer and registered status flags.
   always_ff @(posedge i_clock) begin
      if (!i_RESET) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         o_fault   <= 1'b0;
         o_running <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_enable && !i_fault) begin
                  state <= ST_BOOT;
                  cnt   <= '0;
               end
            end
            ST_BOOT, ST_FORCE, ST_RUN: begin
               if (i_fault || overlap) begin
                  state     <= ST_FAULT;
                  cnt       <= '0;
                  o_fault   <= 1'b1;
                  o_running <= 1'b0;
               end else if (!i_enable) begin
                  state     <= ST_IDLE;
                  cnt       <= '0;
                  o_running <= 1'b0;
               end else if (state == ST_BOOT && cnt >= BOOT_LAST) begin
                  state <= ST_FORCE;
                  cnt   <= '0;
               end else if (state == ST_FORCE && cnt >= VG_LAST) begin
                  state     <= ST_RUN;
                  cnt       <= '0;
                  o_running <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FAULT: begin
               if (!i_enable && !i_fault) begin
                  state   <= ST_IDLE;
                  cnt     <= '0;
                  o_fault <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               cnt       <= '0;
               o_fault   <= 1'b0;
               o_running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hbridge_sequencer.sv
// Bench for hbridge_sequencer: two instances (DEADTIME 20 and 0) share one
// stimulus stream; each is compared every cycle against a reference that
// derives gates as "request held for the last DEADTIME+1 samples".
module tb_hbridge_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        flt;
   logic [1:0]  mode;
   logic [15:0] mos;

   logic [3:0]  q_a, q_b;
   logic [2:0]  st_a, st_b;
   logic        fault_a, fault_b, run_a, run_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hbridge_sequencer #(.DEADTIME(20)) dut_a (
      .i_clock(clk), .i_RESET(rst_n), .i_enable(en), .i_mode(mode),
      .i_MOSFET(mos), .i_fault(flt), .o_Q(q_a), .o_state(st_a),
      .o_fault(fault_a), .o_running(run_a));

   hbridge_sequencer #(.DEADTIME(0)) dut_b (
      .i_clock(clk), .i_RESET(rst_n), .i_enable(en), .i_mode(mode),
      .i_MOSFET(mos), .i_fault(flt), .o_Q(q_b), .o_state(st_b),
      .o_fault(fault_b), .o_running(run_b));

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 boot, 2 force, 3 run, 4 fault
   int         dt[2] = '{20, 0};
   logic [3:0] hist[2][21];
   int         ph[2];
   int         el[2];
   logic [3:0] eq[2];
   logic       ef[2];

   task automatic model_step(input int i);
      logic [3:0] raw, cand;
      int         nxt;
      bit         act, ovl;
      if (!rst_n) begin
         ph[i] = 0; el[i] = 0; eq[i] = 4'h0; ef[i] = 1'b0;
         for (int j = 0; j < 21; j++) hist[i][j] = 4'h0;
         return;
      end
      case (ph[i])
         1:       raw = 4'b1100;
         2:       raw = 4'b1001;
         3:       raw = (mode == 2'd3) ? 4'h0 : mos[4*int'(mode) +: 4];
         default: raw = 4'h0;
      endcase
      for (int j = 20; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = raw;
      cand = 4'hF;
      for (int j = 0; j <= dt[i]; j++) cand &= hist[i][j];
      ovl = |(cand[1:0] & cand[3:2]);
      act = (ph[i] >= 1) && (ph[i] <= 3);
      nxt = ph[i];
      if (ph[i] == 0) begin
         if (en && !flt) nxt = 1;
      end else if (act) begin
         if (flt || ovl)                      nxt = 4;
         else if (!en)                        nxt = 0;
         else if (ph[i] == 1 && el[i] == 999) nxt = 2;
         else if (ph[i] == 2 && el[i] == 999) nxt = 3;
      end else if (!en && !flt) begin
         nxt = 0;
      end
      el[i] = (nxt != ph[i]) ? 0 : el[i] + 1;
      if (nxt == 0 || nxt == 4) begin
         hist[i][0] = 4'h0;
         cand = 4'h0;
      end
      eq[i] = cand;
      ef[i] = (nxt == 4);
      ph[i] = nxt;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      chk("q_dt20",     32'(q_a),     32'(eq[0]));
      chk("state_dt20", 32'(st_a),    32'(ph[0]));
      chk("fault_dt20", 32'(fault_a), 32'(ef[0]));
      chk("run_dt20",   32'(run_a),   32'(ph[0] == 3));
      chk("q_dt0",      32'(q_b),     32'(eq[1]));
      chk("state_dt0",  32'(st_b),    32'(ph[1]));
      chk("fault_dt0",  32'(fault_b), 32'(ef[1]));
      chk("run_dt0",    32'(run_b),   32'(ph[1] == 3));
   endtask

   function automatic logic [15:0] gen_mos();
      logic [15:0] m;
      logic [3:0]  v;
      m = 16'h0;
      for (int s = 0; s < 4; s++) begin
         v = 4'($urandom);
         if ($urandom_range(0, 9) < 8) begin
            v[2] = v[2] & ~v[0];
            v[3] = v[3] & ~v[1];
         end
         m[4*s +: 4] = v;
      end
      return m;
   endfunction

   initial begin
      int c;
      rst_n = 1'b0; en = 1'b0; flt = 1'b0; mode = 2'd0; mos = 16'h0;
      repeat (3) tick();
      chk("rst_state", 32'(st_a), 32'd0);
      chk("rst_q",     32'(q_a),  32'd0);

      // enable during reset release: BOOT on the first edge
      en = 1'b1; rst_n = 1'b1;
      tick();
      chk("boot_entry", 32'(st_a), 32'd1);
      repeat (20) tick();
      chk("boot_q_t20", 32'(q_a), 32'h0);
      tick();
      chk("boot_q_t21", 32'(q_a), 32'hC);
      repeat (979) tick();
      chk("force_entry", 32'(st_a), 32'd2);
      repeat (21) tick();
      chk("force_q", 32'(q_a), 32'h9);
      repeat (979) tick();
      chk("run_entry", 32'(run_a), 32'd1);
      repeat (5) tick();

      // short pulses: 15 cycles never reach the gate, 21 give one cycle
      c = 0;
      mos = 16'h0001;
      repeat (15) begin tick(); if (q_a[0]) c++; end
      mos = 16'h0;
      repeat (25) begin tick(); if (q_a[0]) c++; end
      chk("pulse15", 32'(c), 32'd0);
      c = 0;
      mos = 16'h0001;
      repeat (21) begin tick(); if (q_a[0]) c++; end
      mos = 16'h0;
      repeat (25) begin tick(); if (q_a[0]) c++; end
      chk("pulse21", 32'(c), 32'd1);

      // complementary toggling on leg 0
      for (int r = 0; r < 4; r++) begin
         mos = 16'h0001; repeat (100) tick();
         mos = 16'h0004; repeat (100) tick();
      end

      // both sides requested for one cycle: instant fault only with no dead time
      mos = 16'h0005;
      tick();
      chk("ovl_fault_dt0",  32'(fault_b), 32'd1);
      chk("ovl_state_dt20", 32'(st_a),    32'd3);
      mos = 16'h0;
      repeat (3) tick();

      // external fault, held while enabled, cleared by disabling
      flt = 1'b1;
      tick();
      chk("ext_fault", 32'(fault_a), 32'd1);
      chk("ext_q",     32'(q_a),     32'd0);
      flt = 1'b0;
      repeat (5) tick();
      chk("fault_hold", 32'(st_a), 32'd4);
      en = 1'b0;
      tick();
      chk("fault_clear", 32'(fault_a), 32'd0);
      chk("fault_idle",  32'(st_a),    32'd0);

      // fault and enable-drop together: fault wins
      en = 1'b1; tick();
      flt = 1'b1; en = 1'b0; tick();
      chk("fault_prio", 32'(st_a), 32'd4);
      flt = 1'b0; tick();

      // mid-BOOT disable restarts a full precharge
      en = 1'b1; repeat (501) tick();
      en = 1'b0; tick();
      en = 1'b1; tick();
      repeat (999) tick();
      chk("restart_boot",  32'(st_a), 32'd1);
      tick();
      chk("restart_force", 32'(st_a), 32'd2);
      en = 1'b0; repeat (3) tick();

      // randomized episodes
      for (int ep = 0; ep < 6; ep++) begin
         en = 1'b1; flt = 1'b0;
         mode = 2'($urandom_range(0, 3)); mos = gen_mos();
         if (ep == 2) begin
            repeat ($urandom_range(10, 900)) tick();
            en = 1'b0; tick(); en = 1'b1;
         end
         repeat ($urandom_range(2001, 2030)) tick();
         for (int sg = 0; sg < 25; sg++) begin
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            mos = gen_mos();
            if ($urandom_range(0, 19) == 0) begin flt = 1'b1; tick(); flt = 1'b0; end
            if (ep == 4 && sg == 10) begin rst_n = 1'b0; tick(); rst_n = 1'b1; end
            repeat ($urandom_range(1, 45)) tick();
         end
         en = 1'b0; flt = 1'b0;
         repeat (3) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hbridge_sequencer.md
HBRIDGE_SEQUENCER -- requirements
Module: hbridge_sequencer

Interface
REQ-001 The module SHALL take parameter N_LEG, default 2: number of half-bridge legs.
REQ-002 The module SHALL take parameter N_MODE, default 4: number of selectable gate-pattern sources; the index N_MODE-1 is reserved as all-off.
REQ-003 The module SHALL take parameter DEADTIME, default 20: turn-on delay in clock cycles.
REQ-004 The module SHALL take parameter T_BOOT, default 1000: bootstrap precharge length in cycles.
REQ-005 The module SHALL take parameter T_VG, default 1000: forced-sigma precharge length in cycles.
REQ-006 The module SHALL have port i_clock, input, 1 bit: the single clock for all logic.
REQ-007 The module SHALL have port i_RESET, input, 1 bit: the reset, which is synchronous and active-low.
REQ-008 The module SHALL have port i_enable, input, 1 bit: converter enable, already debounced.
REQ-009 The module SHALL have port i_mode, input, clog2(N_MODE) bits: selects the pattern source.
REQ-010 The module SHALL have port i_MOSFET, input, 2*N_LEG*N_MODE bits: gate requests; slice m is bits [2*N_LEG*(m+1)-1 : 2*N_LEG*m].
REQ-011 The module SHALL have port i_fault, input, 1 bit: external over-voltage or over-current fault, active-high.
REQ-012 The module SHALL have port o_Q, output, 2*N_LEG bits: gate drives; bit k is the high side of leg k and bit N_LEG+k is the low side of leg k.
REQ-013 The module SHALL have port o_state, output, 3 bits: current FSM state.
REQ-014 The module SHALL have port o_fault, output, 1 bit: latched fault flag.
REQ-015 The module SHALL have port o_running, output, 1 bit: high only in RUN.

Function
REQ-016 The FSM SHALL have states IDLE, BOOT, FORCE, RUN and FAULT.
REQ-017 IDLE SHALL drive o_Q all zero, and SHALL go to BOOT on the first cycle i_enable=1 while i_fault=0.
REQ-018 BOOT SHALL drive all low sides on and all high sides off for exactly T_BOOT cycles, then go to FORCE.
REQ-019 FORCE SHALL drive leg 0 high plus every other leg low (sigma=+1) for exactly T_VG cycles, then go to RUN.
REQ-020 RUN SHALL drive o_Q from the dead-time-processed slice i_MOSFET[i_mode]; i_mode=N_MODE-1, or any i_mode>=N_MODE, SHALL request all-off while staying in RUN.
REQ-021 i_enable=0 in any non-FAULT state SHALL go to IDLE next cycle, with o_Q=0 from that cycle; a mid-sequence restart SHALL begin BOOT again from count 0.
REQ-022 i_fault=1 in any state other than IDLE SHALL go to FAULT, set o_fault=1 and force o_Q=0 on the next cycle.
REQ-023 The module SHALL also enter FAULT if any leg's processed high and low gates are both 1.
REQ-024 FAULT SHALL be left only to IDLE, and only when i_enable=0 and i_fault=0; o_fault SHALL clear on that transition.
REQ-025 If i_fault and i_enable fall in the same cycle, FAULT SHALL take priority.
REQ-026 Each gate SHALL have its own dead-time channel: a request rise sampled at cycle t gives o_Q rise at t+DEADTIME+1 if the request stays high throughout.
REQ-027 A request fall sampled at cycle t SHALL give o_Q fall at t+1 and SHALL reload that channel's counter.
REQ-028 Request pulses shorter than DEADTIME+1 cycles SHALL never reach o_Q.
REQ-029 DEADTIME=0 SHALL give a one-cycle registered pass-through.
REQ-030 On BOOT to FORCE and FORCE to RUN, every newly-on gate SHALL also pass through dead time; forced patterns use the same channels.
REQ-031 A change of i_mode SHALL be a plain request change: no extra delay and no glitch beyond the dead-time rules.
REQ-032 The state counter SHALL be clog2(max(T_BOOT,T_VG))+1 bits wide, SHALL saturate rather than wrap, and SHALL reset to 0 on every state entry.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 While i_RESET=0 at a clock edge, the module SHALL set state=IDLE, o_Q=0, o_fault=0, o_running=0, and clear all counters and dead-time channels.
REQ-035 Release of reset with i_enable=1 SHALL enter BOOT on the first cycle after release.
REQ-036 A reset during RUN SHALL take o_Q to 0 on that same edge.

Structure
REQ-037 The state encoding and the ALL_OFF mode constant SHALL live in shared package hbridge_pkg.
REQ-038 One sub-module, dead_time_channel (1-bit, parameter DEADTIME), SHALL be instantiated 2*N_LEG times.
REQ-039 The module SHALL contain no other hierarchy.

Verification
REQ-040 With defaults, raise i_enable -> o_Q low sides (bits 2,3) rise at cycle 21 after the edge and stay on to 1000 cycles, then FORCE gives o_Q=4'b1001 after dead time, then RUN with o_running=1.
REQ-041 In RUN, mode 0, toggle leg 0 high/low complementary every 100 cycles -> each rise lags by 21 cycles, each fall takes 1 cycle, and high and low are never both 1.
REQ-042 Apply a 15-cycle request pulse with DEADTIME=20 -> o_Q stays 0; a 21-cycle pulse -> o_Q shows a 1-cycle pulse.
REQ-043 Assert i_fault in RUN -> o_Q=0 and o_fault=1 next cycle; drop i_fault with i_enable=1 -> stays in FAULT; drop i_enable -> IDLE and o_fault=0.
REQ-044 Deassert i_enable at BOOT cycle 500, then reassert -> BOOT restarts with a full 1000-cycle precharge.
REQ-045 With DEADTIME=0 and i_MOSFET leg 0 = 2'b11 in RUN -> FAULT on the next cycle.
